// File: rtl/matmul_pkg.sv
// Shared definitions for the complex matrix-multiply operand path.
// Holds default sizes, the loader state encoding and the saturating negate helper.
package matmul_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int N_DEF     = 4;

  typedef enum logic {
    FILL = 1'b0,
    PEND = 1'b1
  } ld_state_t;

  // Negate a sign-extended w-bit value; the most negative code maps to the most positive.
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    return (x == lo) ? hi : -x;
  endfunction

endpackage

// File: rtl/operand_bank.sv
// N-slot x 4-word complex operand register bank with per-slot writes,
// whole-bank parallel load and synchronous clear. Clear beats load beats slot writes.
module operand_bank
  import matmul_pkg::*;
#(
  parameter int Width = WIDTH_DEF,
  parameter int N     = N_DEF
) (
  input  logic                 CLK,
  input  logic                 clr,
  input  logic [N-1:0]         wr_en,
  input  logic [Width-1:0]     wr_a_re,
  input  logic [Width-1:0]     wr_a_im,
  input  logic [Width-1:0]     wr_b_re,
  input  logic [Width-1:0]     wr_b_im,
  input  logic                 load,
  input  logic [N*Width-1:0]   ld_a_re,
  input  logic [N*Width-1:0]   ld_a_im,
  input  logic [N*Width-1:0]   ld_b_re,
  input  logic [N*Width-1:0]   ld_b_im,
  output logic [N*Width-1:0]   q_a_re,
  output logic [N*Width-1:0]   q_a_im,
  output logic [N*Width-1:0]   q_b_re,
  output logic [N*Width-1:0]   q_b_im
);

  always_ff @(posedge CLK) begin
    if (clr) begin
      q_a_re <= '0;
      q_a_im <= '0;
      q_b_re <= '0;
      q_b_im <= '0;
    end else if (load) begin
      q_a_re <= ld_a_re;
      q_a_im <= ld_a_im;
      q_b_re <= ld_b_re;
      q_b_im <= ld_b_im;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (wr_en[k]) begin
          q_a_re[k*Width +: Width] <= wr_a_re;
          q_a_im[k*Width +: Width] <= wr_a_im;
          q_b_re[k*Width +: Width] <= wr_b_re;
          q_b_im[k*Width +: Width] <= wr_b_im;
        end
      end
    end
  end

endmodule

// File: rtl/operand_vector_loader.sv
// Serial-to-parallel double-buffered loader for one A row and one B column.
// Optional MATMUL_CONJ_B_EN adds conj_b, storing B imaginary words saturating-negated.
//
// state | meaning
// FILL  | accepting beats into the fill bank (in_ready=1)
// PEND  | complete vector parked in fill bank, waiting for output bank to drain
module operand_vector_loader
  import matmul_pkg::*;
#(
  parameter int Width = WIDTH_DEF,
  parameter int N     = N_DEF
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
`ifdef MATMUL_CONJ_B_EN
  input  logic                 conj_b,
`endif
  input  logic [Width-1:0]     a_in_re,
  input  logic [Width-1:0]     a_in_im,
  input  logic [Width-1:0]     b_in_re,
  input  logic [Width-1:0]     b_in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*Width-1:0]   a_re,
  output logic [N*Width-1:0]   a_im,
  output logic [N*Width-1:0]   b_re,
  output logic [N*Width-1:0]   b_im,
  output logic                 len_err
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  ld_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic            len_err_q, len_err_d;

  logic            accept, at_last, drain, direct, pend_copy, out_load;
  logic [N-1:0]    fill_we;
  logic [Width-1:0] b_im_st;
  logic [N*Width-1:0] fill_a_re, fill_a_im, fill_b_re, fill_b_im;
  logic [N*Width-1:0] ld_a_re, ld_a_im, ld_b_re, ld_b_im;

  assign in_ready  = (state_q == FILL);
  assign out_valid = out_valid_q;
  assign len_err   = len_err_q;

  always_comb begin
    b_im_st = b_in_im;
`ifdef MATMUL_CONJ_B_EN
    if (conj_b) b_im_st = Width'(sat_neg(32'(signed'(b_in_im)), Width));
`endif
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      len_err_q   <= len_err_d;
    end
  end

  always_comb begin
    accept      = in_valid && in_ready && !flush;
    at_last     = (cnt_q == LAST);
    drain       = out_valid_q && out_ready;
    direct      = accept && at_last && (!out_valid_q || out_ready);
    pend_copy   = (state_q == PEND) && drain && !flush;
    out_load    = direct || pend_copy;
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    len_err_d   = 1'b0;
    if (flush) begin
      state_d     = FILL;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (accept) begin
        cnt_d     = at_last ? '0 : cnt_q + CW'(1);
        len_err_d = (in_last != at_last);
        if (at_last && !direct) state_d = PEND;
      end
      if (pend_copy) state_d = FILL;
      if (out_load) out_valid_d = 1'b1;
      else if (drain) out_valid_d = 1'b0;
    end
  end

  always_comb begin
    fill_we = '0;
    for (int k = 0; k < N; k++) fill_we[k] = accept && (cnt_q == CW'(k));
  end

  // The last element bypasses the fill bank when going straight to the output bank.
  always_comb begin
    ld_a_re = fill_a_re;
    ld_a_im = fill_a_im;
    ld_b_re = fill_b_re;
    ld_b_im = fill_b_im;
    if (state_q == FILL) begin
      ld_a_re[(N-1)*Width +: Width] = a_in_re;
      ld_a_im[(N-1)*Width +: Width] = a_in_im;
      ld_b_re[(N-1)*Width +: Width] = b_in_re;
      ld_b_im[(N-1)*Width +: Width] = b_im_st;
    end
  end

  operand_bank #(.Width(Width), .N(N)) u_fill (
    .CLK     (CLK),
    .clr     (reset),
    .wr_en   (fill_we),
    .wr_a_re (a_in_re),
    .wr_a_im (a_in_im),
    .wr_b_re (b_in_re),
    .wr_b_im (b_im_st),
    .load    (1'b0),
    .ld_a_re ('0),
    .ld_a_im ('0),
    .ld_b_re ('0),
    .ld_b_im ('0),
    .q_a_re  (fill_a_re),
    .q_a_im  (fill_a_im),
    .q_b_re  (fill_b_re),
    .q_b_im  (fill_b_im)
  );

  operand_bank #(.Width(Width), .N(N)) u_out (
    .CLK     (CLK),
    .clr     (reset),
    .wr_en   ('0),
    .wr_a_re ('0),
    .wr_a_im ('0),
    .wr_b_re ('0),
    .wr_b_im ('0),
    .load    (out_load),
    .ld_a_re (ld_a_re),
    .ld_a_im (ld_a_im),
    .ld_b_re (ld_b_re),
    .ld_b_im (ld_b_im),
    .q_a_re  (a_re),
    .q_a_im  (a_im),
    .q_b_re  (b_re),
    .q_b_im  (b_im)
  );

endmodule

// File: tb/tb_operand_vector_loader.sv
// Self-checking bench for operand_vector_loader: a queue-based reference model
// (element list + depth-2 vector scoreboard) checked every cycle by a monitor.
module tb_operand_vector_loader;
  import matmul_pkg::*;

  localparam int W = 8;
  localparam int N = 4;

  logic CLK = 1'b0;
  logic reset, flush, in_valid, in_ready, in_last, out_valid, out_ready, len_err;
  logic conj_b;
  logic [W-1:0] a_in_re, a_in_im, b_in_re, b_in_im;
  logic [N*W-1:0] a_re, a_im, b_re, b_im;

  always #5 CLK = ~CLK;

  operand_vector_loader #(.Width(W), .N(N)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
`ifdef MATMUL_CONJ_B_EN
    .conj_b    (conj_b),
`endif
    .a_in_re   (a_in_re),
    .a_in_im   (a_in_im),
    .b_in_re   (b_in_re),
    .b_in_im   (b_in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_re      (a_re),
    .a_im      (a_im),
    .b_re      (b_re),
    .b_im      (b_im),
    .len_err   (len_err)
  );

  typedef struct packed {logic [W-1:0] ar, ai, br, bi;} elem_t;
  typedef struct packed {logic [N*W-1:0] ar, ai, br, bi;} vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] neg_sat_ref(input logic [W-1:0] v);
    int x;
    x = int'($signed(v));
    if (x == -(2 ** (W - 1))) x = 2 ** (W - 1) - 1;
    else x = -x;
    return x[W-1:0];
  endfunction

  // Reference model: updated at each rising edge from the stimulus it drove.
  elem_t elems[$];
  vec_t  inflight[$];
  vec_t  shown;
  logic  exp_len;
  bit    started = 0;
  bit    m_acc, m_drn;
  elem_t m_e;
  vec_t  m_v;
  int    cyc = 0;

  always @(posedge CLK) begin
    cyc++;
    started = 1;
    if (reset) begin
      elems.delete(); inflight.delete(); shown = '0; exp_len = 1'b0;
    end else if (flush) begin
      elems.delete(); inflight.delete(); exp_len = 1'b0;
    end else begin
      m_acc = in_valid && (inflight.size() < 2);
      m_drn = (inflight.size() > 0) && out_ready;
      exp_len = m_acc && (in_last != (elems.size() == N - 1));
      if (m_drn) void'(inflight.pop_front());
      if (m_acc) begin
        m_e.ar = a_in_re; m_e.ai = a_in_im; m_e.br = b_in_re; m_e.bi = b_in_im;
`ifdef MATMUL_CONJ_B_EN
        if (conj_b) m_e.bi = neg_sat_ref(b_in_im);
`endif
        elems.push_back(m_e);
        if (elems.size() == N) begin
          for (int i = 0; i < N; i++) begin
            m_v.ar[i*W +: W] = elems[i].ar;
            m_v.ai[i*W +: W] = elems[i].ai;
            m_v.br[i*W +: W] = elems[i].br;
            m_v.bi[i*W +: W] = elems[i].bi;
          end
          inflight.push_back(m_v);
          elems.delete();
        end
      end
      if (inflight.size() > 0) shown = inflight[0];
    end
  end

  int hs_times[$];
  bit rec_hs = 0;
  int len_pulses = 0;
  int ready_drops = 0;

  always @(negedge CLK) begin
    if (started) begin
      chk("in_ready", in_ready, inflight.size() < 2);
      chk("out_valid", out_valid, inflight.size() > 0);
      chk("len_err", len_err, exp_len);
      chk("a_re", a_re, shown.ar);
      chk("a_im", a_im, shown.ai);
      chk("b_re", b_re, shown.br);
      chk("b_im", b_im, shown.bi);
      if (len_err) len_pulses++;
      if (!in_ready) ready_drops++;
      if (rec_hs && out_valid && out_ready) hs_times.push_back(cyc);
    end
  end

  task automatic send_beat(input logic [W-1:0] ar, input logic [W-1:0] ai,
                           input logic [W-1:0] br, input logic [W-1:0] bi,
                           input logic last, input logic cj);
    int t;
    a_in_re = ar; a_in_im = ai; b_in_re = br; b_in_im = bi;
    in_last = last; conj_b = cj; in_valid = 1'b1;
    t = 0;
    @(negedge CLK);
    while (!in_ready && t < 100) begin
      t++;
      @(negedge CLK);
    end
    chk("beat_accept_wait", in_ready, 1'b1);
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  logic [N*W-1:0] v1, v2, exp_ar;
  logic [W-1:0] r;
  int lp0, dr0;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    conj_b = 1'b0; a_in_re = '0; a_in_im = '0; b_in_re = '0; b_in_im = '0;
    repeat (3) @(posedge CLK);
    #1 reset = 1'b0;
    @(negedge CLK);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_a_re", a_re, 0);
    chk("rst_b_im", b_im, 0);
    @(posedge CLK); #1;

    // Directed vector from the test plan.
    out_ready = 1'b1;
    for (int k = 0; k < N; k++)
      send_beat(W'(k + 1), W'(k + 1), W'(-k), W'(-2 * k), k == N - 1, 1'b0);
    in_valid = 1'b0;
    @(negedge CLK);
    chk("dir_out_valid", out_valid, 1'b1);
    chk("dir_a_re", a_re, 32'h04030201);
    chk("dir_b_re", b_re, 32'hFDFEFF00);
    chk("dir_b_im", b_im, 32'hFAFCFE00);
    chk("dir_len_err", len_err, 1'b0);
    @(posedge CLK); #1;
    idle(3);

    // Back-pressure: second vector parks in PEND.
    out_ready = 1'b0;
    for (int v = 0; v < 2; v++)
      for (int k = 0; k < N; k++) begin
        r = W'($urandom);
        if (v == 0) v1[k*W +: W] = r; else v2[k*W +: W] = r;
        send_beat(r, W'($urandom), W'($urandom), W'($urandom), k == N - 1, 1'b0);
      end
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("pend_in_ready", in_ready, 1'b0);
      chk("pend_hold_a_re", a_re, v1);
    end
    @(posedge CLK); #1 out_ready = 1'b1;
    @(posedge CLK); #1 out_ready = 1'b0;
    @(negedge CLK);
    chk("pend_second_valid", out_valid, 1'b1);
    chk("pend_second_a_re", a_re, v2);
    chk("pend_ready_back", in_ready, 1'b1);
    @(posedge CLK); #1 out_ready = 1'b1;
    idle(3);

    // Early in_last on beat 1.
    lp0 = len_pulses;
    for (int k = 0; k < N; k++)
      send_beat(W'($urandom), W'($urandom), W'($urandom), W'($urandom), (k == 1) || (k == N - 1), 1'b0);
    idle(3);
    chk("len_err_pulses", len_pulses - lp0, 1);

    // Flush mid-vector; presented beat is discarded.
    for (int k = 0; k < 2; k++)
      send_beat(8'h55, 8'h55, 8'h55, 8'h55, 1'b0, 1'b0);
    flush = 1'b1; in_valid = 1'b1;
    @(posedge CLK); #1 flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      exp_ar[k*W +: W] = W'(8'h10 + k);
      send_beat(W'(8'h10 + k), 8'h01, 8'h02, 8'h03, k == N - 1, 1'b0);
    end
    in_valid = 1'b0;
    @(negedge CLK);
    chk("flush_out_valid", out_valid, 1'b1);
    chk("flush_a_re", a_re, exp_ar);
    @(posedge CLK); #1;
    idle(3);

    chk("sat_neg_min8", sat_neg(-32'sd128, 8), 32'sd127);
    chk("sat_neg_5", sat_neg(32'sd5, 8), -32'sd5);
    chk("sat_neg_min16", sat_neg(-32'sd32768, 16), 32'sd32767);
`ifdef MATMUL_CONJ_B_EN
    send_beat(8'h00, 8'h00, 8'h00, 8'h80, 1'b0, 1'b1);
    send_beat(8'h00, 8'h00, 8'h00, 8'h05, 1'b0, 1'b1);
    send_beat(8'h00, 8'h00, 8'h00, 8'h80, 1'b0, 1'b0);
    send_beat(8'h00, 8'h00, 8'h00, 8'h07, 1'b1, 1'b0);
    in_valid = 1'b0;
    @(negedge CLK);
    chk("conj_b_im", b_im, 32'h0780FB7F);
    @(posedge CLK); #1;
    idle(3);
`endif

    // Sustained streaming: one vector every N cycles.
    hs_times.delete();
    dr0 = ready_drops;
    rec_hs = 1;
    for (int v = 0; v < 8; v++)
      for (int k = 0; k < N; k++)
        send_beat(W'($urandom), W'($urandom), W'($urandom), W'($urandom), k == N - 1, 1'($urandom));
    idle(4);
    rec_hs = 0;
    chk("stream_handshakes", hs_times.size(), 8);
    for (int i = 1; i < hs_times.size(); i++)
      chk("stream_spacing", hs_times[i] - hs_times[i-1], N);
    chk("stream_ready_drops", ready_drops - dr0, 0);

    // Randomised traffic with back-pressure and occasional flushes.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      conj_b    = 1'($urandom);
      a_in_re = W'($urandom); a_in_im = W'($urandom);
      b_in_re = W'($urandom); b_in_im = W'($urandom);
      @(posedge CLK); #1;
    end
    flush = 1'b0; out_ready = 1'b1;
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
